// File: rtl/ch0re_ifetch.sv
// Instruction fetch stage: owns the PC, issues credit-limited word fetches and
// queues in-order responses as {pc, instr} pairs for the decoder.
module ch0re_ifetch #(
    parameter int          DEPTH     = 4,
    parameter logic [63:0] BOOT_ADDR = 64'h0000_0000_8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        o_imem_req,
    output logic [63:0] o_imem_addr,
    input  logic        i_imem_ready,
    input  logic        i_imem_rvalid,
    input  logic [31:0] i_imem_rdata,
    input  logic        i_redirect,
    input  logic [63:0] i_redirect_pc,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [31:0] o_instr,
    output logic [63:0] o_pc
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
    } entry_t;

    entry_t        q [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, outstanding, drop_cnt;
    logic [63:0]   pc, rsp_pc, redir_pc;
    logic [CW:0]   credit;
    logic          issue, drop, push, pop;

    // Requests in flight plus queued entries never exceed DEPTH, so every
    // response is guaranteed a slot and memory is never back-pressured.
    assign credit     = {1'b0, outstanding} + {1'b0, count};
    assign o_imem_req = ~rst & ~i_redirect & (credit < (CW+1)'(DEPTH));
    assign issue      = o_imem_req & i_imem_ready;
    assign drop       = i_imem_rvalid & (drop_cnt != '0);
    assign push       = i_imem_rvalid & ~drop & ~i_redirect;
    assign pop        = o_valid & i_ready;
    assign redir_pc   = i_redirect_pc & ~64'h3;

    assign o_imem_addr = pc;
    assign o_valid     = (count != '0);
    assign o_instr     = q[rd_ptr].instr;
    assign o_pc        = q[rd_ptr].pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc          <= BOOT_ADDR;
            rsp_pc      <= BOOT_ADDR;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else if (i_redirect) begin
            // Everything still in flight belongs to the old stream; the response
            // landing this cycle is discarded here, so it is not counted again.
            pc          <= redir_pc;
            rsp_pc      <= redir_pc;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            outstanding <= outstanding - CW'(i_imem_rvalid);
            drop_cnt    <= outstanding - CW'(i_imem_rvalid);
        end else begin
            if (issue) pc <= pc + 64'd4;
            outstanding <= outstanding + CW'(issue) - CW'(i_imem_rvalid);
            if (drop) drop_cnt <= drop_cnt - CW'(1);
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
                rsp_pc <= rsp_pc + 64'd4;
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) q[wr_ptr] <= '{pc: rsp_pc, instr: i_imem_rdata};
    end

    a_drop_le_outstanding: assert property (@(posedge clk) disable iff (rst)
        drop_cnt <= outstanding);

endmodule

// File: tb/tb_ch0re_ifetch.sv
// Bench for ch0re_ifetch: in-order memory model with per-request latency and a
// stream-level reference that tags in-flight fetches as live or stale.
module tb_ch0re_ifetch;
    localparam int          DEPTH = 4;
    localparam logic [63:0] BOOT  = 64'h0000_0000_8000_0000;

    logic        clk, rst;
    logic        o_imem_req;
    logic [63:0] o_imem_addr;
    logic        i_imem_ready, i_imem_rvalid;
    logic [31:0] i_imem_rdata;
    logic        i_redirect;
    logic [63:0] i_redirect_pc;
    logic        o_valid, i_ready;
    logic [31:0] o_instr;
    logic [63:0] o_pc;

    ch0re_ifetch #(.DEPTH(DEPTH), .BOOT_ADDR(BOOT)) dut (
        .clk(clk), .rst(rst),
        .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr),
        .i_imem_ready(i_imem_ready), .i_imem_rvalid(i_imem_rvalid),
        .i_imem_rdata(i_imem_rdata),
        .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc),
        .o_valid(o_valid), .i_ready(i_ready),
        .o_instr(o_instr), .o_pc(o_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [63:0] addr;
        logic [31:0] data;
        bit          live;
    } mreq_t;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
    } ent_t;

    mreq_t       mq[$];
    ent_t        eq[$];
    logic [63:0] m_pc;
    int          cyc, last_due, lat, dut_iss;
    int          total, bad;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        i_redirect = 1'b0; i_redirect_pc = '0; i_ready = 1'b0;
        i_imem_ready = 1'b0; i_imem_rvalid = 1'b0; i_imem_rdata = '0;
        mq.delete(); eq.delete();
        m_pc = BOOT; last_due = 0;
        #1;
        chk("rst_valid", o_valid, 0);
        chk("rst_req", o_imem_req, 0);
        chk("rst_addr", o_imem_addr, BOOT);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
    endtask

    // Drive one cycle's inputs just after the edge; memory answers in order.
    task automatic cyc_begin(input bit redir, input logic [63:0] rpc, input bit rdy, input bit mrdy);
        @(posedge clk);
        #1;
        cyc++;
        i_redirect = redir; i_redirect_pc = rpc; i_ready = rdy; i_imem_ready = mrdy;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            i_imem_rvalid = 1'b1;
            i_imem_rdata  = mq[0].data;
        end else begin
            i_imem_rvalid = 1'b0;
            i_imem_rdata  = $urandom;
        end
        #1;
    endtask

    // Compare against the reference, then advance it across the coming edge.
    task automatic cyc_end();
        bit    exp_req;
        mreq_t r, n;
        exp_req = (mq.size() + eq.size() < DEPTH) && !i_redirect;
        chk("imem_req", o_imem_req, exp_req);
        chk("imem_addr", o_imem_addr, m_pc);
        chk("o_valid", o_valid, eq.size() != 0);
        if (eq.size() != 0) begin
            chk("o_pc", o_pc, eq[0].pc);
            chk("o_instr", o_instr, eq[0].instr);
        end
        if (o_imem_req && i_imem_ready) dut_iss++;
        r.live = 1'b0;
        if (i_imem_rvalid) r = mq.pop_front();
        if (i_redirect) begin
            eq.delete();
            foreach (mq[k]) mq[k].live = 1'b0;
            m_pc = {i_redirect_pc[63:2], 2'b00};
        end else begin
            if (eq.size() != 0 && i_ready) void'(eq.pop_front());
            if (i_imem_rvalid && r.live) eq.push_back('{pc: r.addr, instr: r.data});
            if (exp_req && i_imem_ready) begin
                n.due  = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
                last_due = n.due;
                n.addr = m_pc;
                n.data = $urandom;
                n.live = 1'b1;
                mq.push_back(n);
                m_pc = m_pc + 64'd4;
            end
        end
    endtask

    task automatic run_until_valid(input string nm, input logic [63:0] exp);
        bit seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            cyc_begin(1'b0, '0, 1'b1, 1'b1);
            if (o_valid) begin
                chk(nm, o_pc, exp);
                seen = 1'b1;
            end
            cyc_end();
        end
        if (!seen) begin
            total++; bad++;
            $display("FAIL %s: timeout, no o_valid within 20 cycles", nm);
        end
    endtask

    initial begin
        total = 0; bad = 0; cyc = 0; lat = 1; dut_iss = 0;

        // streaming with 1-cycle memory
        do_reset();
        lat = 1;
        for (int i = 0; i < 6; i++) begin
            cyc_begin(1'b0, '0, 1'b1, 1'b1);
            if (i < 3) chk("s1_addr", o_imem_addr, BOOT + 64'(4 * i));
            if (i == 2) begin
                chk("s1_valid", o_valid, 1);
                chk("s1_pc", o_pc, BOOT);
            end
            cyc_end();
        end

        // decode stalled: credit limits fetches to DEPTH
        do_reset();
        dut_iss = 0;
        for (int i = 0; i < 10; i++) begin
            cyc_begin(1'b0, '0, 1'b0, 1'b1);
            cyc_end();
        end
        cyc_begin(1'b0, '0, 1'b0, 1'b1);
        chk("s2_req", o_imem_req, 0);
        chk("s2_pc", o_pc, BOOT);
        chk("s2_issued", 64'(dut_iss), 64'd4);
        cyc_end();
        for (int i = 0; i < 8; i++) begin
            cyc_begin(1'b0, '0, 1'b1, 1'b1);
            cyc_end();
        end

        // redirect with three fetches in flight on a 3-cycle memory
        do_reset();
        lat = 3;
        for (int i = 0; i < 3; i++) begin
            cyc_begin(1'b0, '0, 1'b1, 1'b1);
            cyc_end();
        end
        cyc_begin(1'b1, 64'h0000_0000_8000_0103, 1'b1, 1'b1);
        chk("s3_req_off", o_imem_req, 0);
        cyc_end();
        cyc_begin(1'b0, '0, 1'b1, 1'b1);
        chk("s3_addr", o_imem_addr, 64'h0000_0000_8000_0100);
        chk("s3_empty", o_valid, 0);
        cyc_end();
        run_until_valid("s3_first_pc", 64'h0000_0000_8000_0100);

        // redirect coinciding with a response and a decode pop
        do_reset();
        lat = 1;
        for (int i = 0; i < 4; i++) begin
            cyc_begin(1'b0, '0, 1'b1, 1'b1);
            cyc_end();
        end
        cyc_begin(1'b1, 64'h0000_0000_8000_1000, 1'b1, 1'b1);
        chk("s4_valid_pre", o_valid, 1);
        cyc_end();
        cyc_begin(1'b0, '0, 1'b1, 1'b1);
        chk("s4_flushed", o_valid, 0);
        chk("s4_addr", o_imem_addr, 64'h0000_0000_8000_1000);
        cyc_end();
        run_until_valid("s4_first_pc", 64'h0000_0000_8000_1000);

        // back-to-back redirects: last one wins
        do_reset();
        lat = 2;
        for (int i = 0; i < 3; i++) begin
            cyc_begin(1'b0, '0, 1'b1, 1'b1);
            cyc_end();
        end
        cyc_begin(1'b1, 64'h100, 1'b1, 1'b1);
        cyc_end();
        cyc_begin(1'b1, 64'h200, 1'b1, 1'b1);
        cyc_end();
        run_until_valid("s5_first_pc", 64'h200);

        // reset with two fetches outstanding
        do_reset();
        lat = 3;
        for (int i = 0; i < 2; i++) begin
            cyc_begin(1'b0, '0, 1'b1, 1'b1);
            cyc_end();
        end
        do_reset();
        cyc_begin(1'b0, '0, 1'b1, 1'b1);
        chk("s6_addr", o_imem_addr, BOOT);
        chk("s6_req", o_imem_req, 1);
        cyc_end();
        run_until_valid("s6_first_pc", BOOT);

        // randomized traffic
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) do_reset();
            lat = $urandom_range(1, 4);
            cyc_begin($urandom_range(0, 19) == 0, {$urandom, $urandom},
                      $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
            cyc_end();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
